sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
// - Shares one single-port SRAM macro (csb0/web0/addr0/din0/dout0, active-low controls)
//   between NUM_REQ requesters. Each requester uses a valid/ready command channel and a
//   read-response channel.
// - Round-robin grant, one access per cycle, registered SRAM-side outputs.
// - Read data is routed back to the requester that issued the read, after a fixed latency.
// PARAMETERS
// - NUM_REQ       2   number of requesters, 2..8
// - ADDR_WIDTH    4   SRAM address width
// - DATA_WIDTH    2   SRAM data width
// - READ_LATENCY  1   cycles from the SRAM capture edge until sram_dout0 is valid, 1..4
// PORTS
// - clk0        in   1                     single clock; all logic on its rising edge
// - rst0_n      in   1                     synchronous, active-low reset
// - req_valid   in   NUM_REQ               per-requester command valid
// - req_ready   out  NUM_REQ               per-requester command accepted this cycle
// - req_we      in   NUM_REQ               1=write, 0=read
// - req_addr    in   NUM_REQ*ADDR_WIDTH    packed addresses; requester i at [i*AW +: AW]
// - req_wdata   in   NUM_REQ*DATA_WIDTH    packed write data; requester i at [i*DW +: DW]
// - resp_valid  out  NUM_REQ               one-cycle read-data strobe per requester
// - resp_rdata  out  DATA_WIDTH            read data, shared; qualified by resp_valid
// - sram_csb0   out  1                     registered chip select, active low
// - sram_web0   out  1                     registered write enable, active low
// - sram_addr0  out  ADDR_WIDTH            registered address
// - sram_din0   out  DATA_WIDTH            registered write data
// - sram_dout0  in   DATA_WIDTH            SRAM read data
// BEHAVIOUR
// - Reset (rst0_n=0 at an edge):
//   - outputs: sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0.
//   - req_ready=0 while rst0_n=0; resp_valid=0.
//   - RR pointer set so requester 0 has top priority.
//   - All in-flight read tags cleared: responses in flight are dropped, never delivered.
// - Grant (combinational):
//   - At most one req_ready bit is high.
//   - ready[i]=1 iff valid[i]=1 and i is the first valid requester searching from
//     (last_grant+1) mod NUM_REQ upward.
//   - No valid requester -> req_ready=0.
// - Handshake:
//   - A command transfers at an edge where valid&ready.
//   - The requester holds valid, we, addr and wdata stable until the transfer.
//   - On transfer, last_grant<=i.
// - SRAM issue:
//   - The command accepted at edge E0 drives the sram_* registers during E0..E1.
//   - csb0=0; web0=~we; din0=wdata (write) or holds its previous value (read).
//   - The SRAM captures it at E1.
//   - A cycle with no transfer drives csb0=1, web0=1; addr0/din0 hold their values.
// - Read return:
//   - Tag shift register of depth 1+READ_LATENCY carries {is_read, requester id}.
//   - resp_valid[id] is high for exactly one cycle, READ_LATENCY cycles after the E1
//     capture edge (cycle E1..E2 when READ_LATENCY=1).
//   - resp_rdata=sram_dout0 combinationally.
//   - Writes produce no response.
// - Throughput: one access per cycle; back-to-back reads return in issue order.
// - Same-address hazards:
//   - The SRAM resolves accesses in issue order.
//   - A read issued the cycle after a write to the same address returns the new data.
// - Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once
//   every NUM_REQ cycles.
// - Reset mid-operation: a read accepted before reset yields no resp_valid after reset.
// TESTING
// - Reset: hold rst0_n=0 3 cycles with all valid=1.
//   -> req_ready=0, sram_csb0=1, sram_web0=1, resp_valid=0 throughout.
// - Single write then read, requester 0 (addr=5, wdata=2'b10, then read addr=5):
//   -> csb0=0,web0=0 then csb0=0,web0=1 on consecutive cycles.
//   -> resp_valid=2'b01, resp_rdata=2'b10 two cycles after the read handshake.
// - Both requesters valid every cycle, 8 cycles:
//   -> grants alternate 0,1,0,1...; each receives 4 grants.
// - Interleaved reads: req0 addr=1, req1 addr=2, preloaded with 1 and 3.
//   -> resp_valid 01 then 10 on consecutive cycles with data 1 then 3.
// - Idle gap: valid=0 for 2 cycles.
//   -> csb0=1 both cycles, addr0 unchanged, no resp_valid.
// - Reset during read: reset asserted the cycle after a read handshake.
//   -> no resp_valid ever appears for that read; the next grant goes to requester 0.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Requester command/response channels plus the SRAM macro pins of the shared port.
interface sram_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_rdata;
  logic                          sram_csb0;
  logic                          sram_web0;
  logic [ADDR_WIDTH-1:0]         sram_addr0;
  logic [DATA_WIDTH-1:0]         sram_din0;
  logic [DATA_WIDTH-1:0]         sram_dout0;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, sram_dout0,
    output req_ready, resp_valid, resp_rdata,
           sram_csb0, sram_web0, sram_addr0, sram_din0
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, sram_dout0,
    input  req_ready, resp_valid, resp_rdata,
           sram_csb0, sram_web0, sram_addr0, sram_din0
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin sharing of one single-port SRAM among NUM_REQ requesters; read data is
// steered back to the issuing requester through a tag pipeline matched to the SRAM latency.
module sram_port_arbiter_lane #(
  parameter int IDW  = 1,
  parameter int LANE = 0
) (
  input  logic           grant_en,
  input  logic [IDW-1:0] grant_id,
  input  logic           tag_rd,
  input  logic [IDW-1:0] tag_id,
  output logic           ready,
  output logic           resp_valid
);
  localparam logic [IDW-1:0] MY_ID = IDW'(LANE);

  assign ready      = grant_en & (grant_id == MY_ID);
  assign resp_valid = tag_rd   & (tag_id   == MY_ID);
endmodule

module sram_port_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk0,
  input  logic                rst0_n,
  sram_port_arbiter_if.slave  bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic           rd;
    logic [IDW-1:0] id;
  } tag_t;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v;
  logic [NUM_REQ-1:0]                 ready_v;
  logic [NUM_REQ-1:0]                 resp_v;

  logic [IDW-1:0]        last_grant;
  logic [IDW-1:0]        grant_id;
  logic [IDW-1:0]        cand;
  logic                  found;
  logic                  xfer;
  logic                  we_sel;
  logic                  resp_en;

  logic                  csb_q;
  logic                  web_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;

  // stage 0 travels with the SRAM command; the last stage lines up with valid dout
  tag_t [READ_LATENCY:0] tag_pipe;

  assign addr_v  = bus.req_addr;
  assign wdata_v = bus.req_wdata;

  // first valid requester at or after last_grant+1, wrapping
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(last_grant) + 1 + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
  end

  assign xfer    = rst0_n & found;
  assign we_sel  = bus.req_we[grant_id];
  assign resp_en = rst0_n & tag_pipe[READ_LATENCY].rd;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    sram_port_arbiter_lane #(
      .IDW  (IDW),
      .LANE (i)
    ) u_lane (
      .grant_en   (xfer),
      .grant_id   (grant_id),
      .tag_rd     (resp_en),
      .tag_id     (tag_pipe[READ_LATENCY].id),
      .ready      (ready_v[i]),
      .resp_valid (resp_v[i])
    );
  end

  always_ff @(posedge clk0) begin
    if (!rst0_n) begin
      csb_q      <= 1'b1;
      web_q      <= 1'b1;
      addr_q     <= '0;
      din_q      <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      tag_pipe   <= '0;
    end else begin
      tag_pipe[0] <= '{rd: xfer & ~we_sel, id: grant_id};
      for (int k = 1; k <= READ_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
      csb_q <= ~xfer;
      web_q <= ~(xfer & we_sel);
      if (xfer) begin
        addr_q     <= addr_v[grant_id];
        last_grant <= grant_id;
        // reads leave din alone so the macro inputs toggle only when needed
        if (we_sel) din_q <= wdata_v[grant_id];
      end
    end
  end

  assign bus.req_ready  = ready_v;
  assign bus.resp_valid = resp_v;
  assign bus.resp_rdata = bus.sram_dout0;
  assign bus.sram_csb0  = csb_q;
  assign bus.sram_web0  = web_q;
  assign bus.sram_addr0 = addr_q;
  assign bus.sram_din0  = din_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM macro, per-requester command slots and
// a queue-based reference model checked every cycle with immediate assertions.
module tb_sram_port_arbiter;
  localparam int NR = 2;
  localparam int AW = 4;
  localparam int DW = 2;
  localparam int RL = 1;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  logic clk0 = 1'b0;
  logic rst0_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc <= cyc + 1;

  sram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_port_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
  ) dut (
    .clk0   (clk0),
    .rst0_n (rst0_n),
    .bus    (bus)
  );

  // behavioural single-port SRAM macro with one cycle of read latency
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] dout_q;
  always @(posedge clk0) begin
    if (!bus.sram_csb0) begin
      if (!bus.sram_web0) sram_mem[bus.sram_addr0] <= bus.sram_din0;
      else                dout_q <= sram_mem[bus.sram_addr0];
    end
  end
  assign bus.sram_dout0 = dout_q;

  // requester command slots: a slot stays valid until its command is granted
  logic [NR-1:0] slot_v;
  logic [NR-1:0] slot_we;
  logic [AW-1:0] slot_a  [NR];
  logic [DW-1:0] slot_wd [NR];
  int            act_grants [NR];

  // reference model state
  logic [DW-1:0] m_mem [1<<AW];
  int            m_last;
  logic          m_csb, m_web;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  rsp_t          rq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cmd(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    slot_v[i]  = 1'b1;
    slot_we[i] = we;
    slot_a[i]  = a;
    slot_wd[i] = wd;
  endtask

  task automatic model_reset();
    m_last = NR - 1;
    m_csb  = 1'b1;
    m_web  = 1'b1;
    m_addr = '0;
    m_din  = '0;
    rq.delete();
  endtask

  // one clock cycle: drive, check against the model, advance the model across the edge
  task automatic step();
    int            g;
    int            idx;
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] exp_rv;
    logic [DW-1:0] exp_rd;
    bus.req_valid = slot_v;
    bus.req_we    = slot_we;
    for (int i = 0; i < NR; i++) begin
      bus.req_addr[i*AW +: AW]  = slot_a[i];
      bus.req_wdata[i*DW +: DW] = slot_wd[i];
    end
    #1;
    g = -1;
    if (rst0_n)
      for (int k = 0; k < NR; k++) begin
        idx = (m_last + 1 + k) % NR;
        if (g < 0 && slot_v[idx]) g = idx;
      end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    if (!rst0_n) rq.delete();
    exp_rv = '0;
    exp_rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_rv[rq[0].id] = 1'b1;
      exp_rd = rq[0].data;
      void'(rq.pop_front());
    end
    check("req_ready",  32'(bus.req_ready),  32'(exp_rdy));
    check("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
    if (|exp_rv) check("resp_rdata", 32'(bus.resp_rdata), 32'(exp_rd));
    check("sram_csb0",  32'(bus.sram_csb0),  32'(m_csb));
    check("sram_web0",  32'(bus.sram_web0),  32'(m_web));
    check("sram_addr0", 32'(bus.sram_addr0), 32'(m_addr));
    check("sram_din0",  32'(bus.sram_din0),  32'(m_din));
    for (int i = 0; i < NR; i++)
      if (bus.req_ready[i] && slot_v[i]) act_grants[i]++;
    if (!rst0_n) model_reset();
    else if (g >= 0) begin
      m_last = g;
      m_csb  = 1'b0;
      m_web  = ~slot_we[g];
      m_addr = slot_a[g];
      if (slot_we[g]) begin
        m_din = slot_wd[g];
        m_mem[slot_a[g]] = slot_wd[g];
      end else begin
        rq.push_back('{g, m_mem[slot_a[g]], cyc + 1 + RL});
      end
      slot_v[g] = 1'b0;
    end else begin
      m_csb = 1'b1;
      m_web = 1'b1;
    end
    @(posedge clk0);
    @(negedge clk0);
  endtask

  initial begin
    int g0, g1;
    rst0_n = 1'b0;
    slot_v = '0;
    slot_we = '0;
    for (int i = 0; i < NR; i++) begin
      slot_a[i] = '0;
      slot_wd[i] = '0;
      act_grants[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    @(posedge clk0);
    @(negedge clk0);
    model_reset();

    // reset held with every requester asking for a read
    for (int i = 0; i < NR; i++) cmd(i, 1'b0, AW'(i), '0);
    repeat (3) step();
    slot_v = '0;
    rst0_n = 1'b1;

    // preload every address so later reads compare known data
    for (int a = 0; a < (1 << AW); a++) begin
      cmd(a % NR, 1'b1, AW'(a), DW'($urandom));
      step();
    end

    // requester 0: write then read-after-write to the same address
    cmd(0, 1'b1, 4'd5, 2'b10);
    step();
    cmd(0, 1'b0, 4'd5, 2'b00);
    repeat (3) step();
    check("raw_data_model", 32'(m_mem[5]), 32'h2);

    // both requesters continuously valid
    for (int i = 0; i < NR; i++) act_grants[i] = 0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NR; i++)
        if (!slot_v[i]) cmd(i, 1'($urandom), AW'($urandom), DW'($urandom));
      step();
    end
    for (int i = 0; i < NR; i++) check("fair_grants", 32'(act_grants[i]), 32'(8 / NR));
    while (slot_v != '0) step();
    repeat (2) step();

    // interleaved reads after preloading 1 and 3
    cmd(0, 1'b1, 4'd1, 2'd1);
    cmd(1, 1'b1, 4'd2, 2'd3);
    repeat (2) step();
    cmd(0, 1'b0, 4'd1, 2'd0);
    cmd(1, 1'b0, 4'd2, 2'd0);
    repeat (4) step();

    // idle gap
    repeat (2) step();

    // reset the cycle after a read handshake: response is dropped, requester 0 wins next
    cmd(1, 1'b0, 4'd3, 2'd0);
    step();
    rst0_n = 1'b0;
    step();
    rst0_n = 1'b1;
    g0 = act_grants[0];
    g1 = act_grants[1];
    cmd(0, 1'b0, 4'd4, 2'd0);
    cmd(1, 1'b0, 4'd6, 2'd0);
    step();
    check("post_reset_grant0", 32'(act_grants[0] - g0), 32'd1);
    check("post_reset_grant1", 32'(act_grants[1] - g1), 32'd0);
    repeat (4) step();

    // randomized traffic with occasional one-cycle resets
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++)
        if (!slot_v[i] && $urandom_range(0, 2) != 0)
          cmd(i, 1'($urandom), AW'($urandom), DW'($urandom));
      rst0_n = ($urandom_range(0, 63) != 0);
      step();
    end
    rst0_n = 1'b1;
    slot_v = '0;
    repeat (4) step();
    check("resp_queue_drained", 32'(rq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
